// File: rtl/adsb_tx_encoder_pkg.sv
// Shared constants, state encoding and preamble shape helper for the ADS-B
// 1090ES transmit encoder.
package adsb_tx_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_GUARD    = 2'd3
  } tx_state_e;

  localparam int unsigned PREAMBLE_US = 8;
  localparam logic [6:0]  LONG_BITS   = 7'd112;
  localparam logic [6:0]  SHORT_BITS  = 7'd56;

  // Preamble pulses start at 0, 1.0, 3.5 and 4.5 us and are 0.5 us (one half) wide.
  function automatic logic preamble_level(input logic [11:0] sc, input logic [11:0] half);
    logic [11:0] h2;
    logic [11:0] h7;
    logic [11:0] h9;
    h2 = 12'd2 * half;
    h7 = 12'd7 * half;
    h9 = 12'd9 * half;
    return (sc < half)
         | ((sc >= h2) & (sc < h2 + half))
         | ((sc >= h7) & (sc < h7 + half))
         | ((sc >= h9) & (sc < h9 + half));
  endfunction

endpackage

// File: rtl/adsb_tx_encoder.sv
// Mode S / ADS-B 1090ES frame encoder: 8 us preamble followed by PPM data bits,
// emitted as a registered RF keying envelope, one sample per ena cycle.
module adsb_tx_encoder
  import adsb_tx_encoder_pkg::*;
#(
  parameter int unsigned SPU      = 20,
  parameter int unsigned GUARD_US = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ena,
  input  logic         start,
  input  logic         long_frame,
  input  logic [111:0] frame_data,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic         tx_pulse,
  output logic         trigger,
  output logic         data_start
);

  localparam logic [11:0] HALF       = 12'(SPU / 2);
  localparam logic [11:0] PRE_LAST   = 12'(PREAMBLE_US * SPU - 1);
  localparam logic [11:0] BIT_LAST   = 12'(SPU - 1);
  localparam logic [11:0] GUARD_LAST = 12'(GUARD_US * SPU - 1);

  tx_state_e    state_q, state_d;
  logic [11:0]  sc_q, sc_d;
  logic [6:0]   bitc_q, bitc_d;
  logic [6:0]   nbits_q, nbits_d;
  logic [111:0] shreg_q, shreg_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         tx_q, tx_d;
  logic         trig_q, trig_d;
  logic         dstart_q, dstart_d;

  // Next-state and registered-output computation; strobes default low so they
  // can only rise on ena cycles.
  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    bitc_d   = bitc_q;
    nbits_d  = nbits_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    trig_d   = 1'b0;
    dstart_d = 1'b0;
    done_d   = 1'b0;
    if (done_q) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (ena) begin
      case (state_q)
        ST_IDLE: begin
          tx_d = 1'b0;
          if (start) begin
            shreg_d = frame_data;
            nbits_d = long_frame ? LONG_BITS : SHORT_BITS;
            sc_d    = 12'd0;
            bitc_d  = 7'd0;
            busy_d  = 1'b1;
            state_d = ST_PREAMBLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PREAMBLE: begin
          if (abort) begin
            tx_d    = 1'b0;
            sc_d    = 12'd0;
            state_d = ST_GUARD;
          end else begin
            tx_d   = preamble_level(sc_q, HALF);
            trig_d = (sc_q == 12'd0);
            if (sc_q == PRE_LAST) begin
              sc_d    = 12'd0;
              bitc_d  = 7'd0;
              state_d = ST_DATA;
            end else begin
              sc_d = sc_q + 12'd1;
            end
          end
        end
        ST_DATA: begin
          if (abort) begin
            tx_d    = 1'b0;
            sc_d    = 12'd0;
            state_d = ST_GUARD;
          end else begin
            // PPM: a one keys the first half of the bit, a zero the second half.
            tx_d     = shreg_q[111] ? (sc_q < HALF) : (sc_q >= HALF);
            dstart_d = (sc_q == 12'd0) && (bitc_q == 7'd0);
            if (sc_q == BIT_LAST) begin
              sc_d    = 12'd0;
              shreg_d = shreg_q << 1;
              if (bitc_q == nbits_q - 7'd1) begin
                bitc_d  = 7'd0;
                state_d = ST_GUARD;
              end else begin
                bitc_d = bitc_q + 7'd1;
              end
            end else begin
              sc_d = sc_q + 12'd1;
            end
          end
        end
        ST_GUARD: begin
          tx_d = 1'b0;
          if (sc_q == GUARD_LAST) begin
            sc_d    = 12'd0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            sc_d = sc_q + 12'd1;
          end
        end
        default: begin
          tx_d    = 1'b0;
          busy_d  = 1'b0;
          sc_d    = 12'd0;
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sc_q     <= 12'd0;
      bitc_q   <= 7'd0;
      nbits_q  <= 7'd0;
      shreg_q  <= 112'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tx_q     <= 1'b0;
      trig_q   <= 1'b0;
      dstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sc_q     <= sc_d;
      bitc_q   <= bitc_d;
      nbits_q  <= nbits_d;
      shreg_q  <= shreg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      tx_q     <= tx_d;
      trig_q   <= trig_d;
      dstart_q <= dstart_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign tx_pulse   = tx_q;
  assign trigger    = trig_q;
  assign data_start = dstart_q;

endmodule

// File: tb/tb_adsb_tx_encoder.sv
// Self-checking bench for adsb_tx_encoder: table-driven frames, random frames
// and hand-written reset sequences, checked against a sample-level envelope model.
module tb_adsb_tx_encoder;

  localparam int SPU      = 20;
  localparam int GUARD_US = 4;
  localparam int GUARD    = GUARD_US * SPU;
  localparam int PRE      = 8 * SPU;

  logic         clock;
  logic         reset;
  logic         ena;
  logic         start;
  logic         long_frame;
  logic [111:0] frame_data;
  logic         abort;
  logic         busy;
  logic         done;
  logic         tx_pulse;
  logic         trigger;
  logic         data_start;

  int n_checks = 0;
  int n_err    = 0;

  adsb_tx_encoder #(.SPU(SPU), .GUARD_US(GUARD_US)) dut (
    .clock      (clock),
    .reset      (reset),
    .ena        (ena),
    .start      (start),
    .long_frame (long_frame),
    .frame_data (frame_data),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .tx_pulse   (tx_pulse),
    .trigger    (trigger),
    .data_start (data_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [111:0] fd;
    bit           lng;
    int           div;
    int           abort_at;
    bit           poke;
    int           exp_done;
    int           exp_ds;
  } vec_t;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Envelope sample s of a frame, straight from pulse positions and PPM rules.
  function automatic bit model_env(input logic [111:0] fd, input int s);
    int h, p, k;
    int offs_half_us [4];
    offs_half_us = '{0, 2, 7, 9};
    h = SPU / 2;
    if (s < PRE) begin
      for (int i = 0; i < 4; i++)
        if (s >= offs_half_us[i] * h && s < offs_half_us[i] * h + h) return 1'b1;
      return 1'b0;
    end
    p = s - PRE;
    k = p / SPU;
    if (fd[111 - k]) return (p % SPU) < h;
    return (p % SPU) >= h;
  endfunction

  function automatic int frame_len(input bit lng);
    return PRE + (lng ? 112 : 56) * SPU;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_frame(input logic [111:0] fd, input bit lng, input int div,
                           input int abort_at, input bit poke,
                           input int exp_done, input int exp_ds);
    int stop, k, cyc, env_err, first_bad, trig_n, trig_k, ds_n, ds_k, done_n, done_k;
    int ena0_err, busy_err;
    bit e, prev_tx;
    stop = (abort_at >= 0) ? abort_at : frame_len(lng);
    env_err = 0; first_bad = -1; trig_n = 0; trig_k = -1; ds_n = 0; ds_k = -1;
    done_n = 0; done_k = -1; ena0_err = 0; busy_err = 0;
    ena = 1'b1; start = 1'b1; long_frame = lng; frame_data = fd; abort = 1'b0;
    tick();
    start = 1'b0;
    long_frame = ~lng;
    frame_data = {$urandom, $urandom, $urandom, $urandom};
    check("busy_after_accept", int'(busy), 1);
    k = 0; cyc = 0; prev_tx = tx_pulse;
    while (done_n == 0 && cyc < 4000 * div) begin
      cyc++;
      ena   = ((cyc % div) == 0);
      abort = ena && (k == abort_at);
      start = poke && k >= 50 && k < 60;
      tick();
      if (ena) begin
        k++;
        e = (k - 1 < stop) ? model_env(fd, k - 1) : 1'b0;
        if (tx_pulse !== e) begin
          env_err++;
          if (first_bad < 0) first_bad = k - 1;
        end
        if (trigger)    begin trig_n++; trig_k = k - 1; end
        if (data_start) begin ds_n++;   ds_k = k - 1;   end
        if (done)       begin done_n++; done_k = k;     end
        if (!done && busy !== 1'b1) busy_err++;
      end else begin
        if (tx_pulse !== prev_tx || trigger || data_start || done) ena0_err++;
      end
      prev_tx = tx_pulse;
    end
    abort = 1'b0; start = 1'b0;
    check("busy_in_done_cycle", int'(busy), 1);
    ena = 1'b1;
    tick();
    check("busy_after_done", int'(busy), 0);
    check("done_single_pulse", int'(done), 0);
    check("envelope_errors", env_err, 0);
    if (env_err != 0) $display("  first bad envelope sample %0d", first_bad);
    check("trigger_count", trig_n, (abort_at == 0) ? 0 : 1);
    check("trigger_sample", trig_k, (abort_at == 0) ? -1 : 0);
    check("data_start_count", ds_n, (exp_ds < 0) ? 0 : 1);
    check("data_start_sample", ds_k, exp_ds);
    check("done_ena_cycle", done_k, exp_done);
    check("ena_low_activity", ena0_err, 0);
    check("busy_during_frame", busy_err, 0);
  endtask

  localparam logic [111:0] GOLD_L = 112'h8D4840D6202CC371C32CE0576098;
  localparam logic [55:0]  GOLD_S56 = 56'h5D4840D699A2CF;

  vec_t vecs [6];

  initial begin
    logic [111:0] gold_s;
    int bad, len, ab, dsv;
    bit lng;
    int dv;
    gold_s = {GOLD_S56, 56'd0};
    vecs[0] = '{GOLD_L, 1'b1, 1, -1,   1'b0, 2400 + GUARD, PRE};
    vecs[1] = '{gold_s, 1'b0, 4, -1,   1'b0, 1280 + GUARD, PRE};
    vecs[2] = '{GOLD_L, 1'b1, 1, 500,  1'b1, 500 + 1 + GUARD, PRE};
    vecs[3] = '{gold_s, 1'b0, 1, 100,  1'b0, 100 + 1 + GUARD, -1};
    vecs[4] = '{GOLD_L, 1'b1, 2, 2399, 1'b0, 2400 + GUARD, PRE};
    vecs[5] = '{gold_s, 1'b0, 1, 1279, 1'b0, 1280 + GUARD, PRE};

    reset = 1'b1; ena = 1'b0; start = 1'b0; long_frame = 1'b0;
    frame_data = 112'd0; abort = 1'b0;
    repeat (3) tick();
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_tx", int'(tx_pulse), 0);
    check("reset_trigger", int'(trigger), 0);
    check("reset_data_start", int'(data_start), 0);
    reset = 1'b0; ena = 1'b1;

    // Idle with no start: nothing may move.
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (tx_pulse || busy || done || trigger || data_start) bad++;
    end
    check("idle_activity", bad, 0);

    for (int v = 0; v < 6; v++)
      run_frame(vecs[v].fd, vecs[v].lng, vecs[v].div, vecs[v].abort_at,
                vecs[v].poke, vecs[v].exp_done, vecs[v].exp_ds);

    for (int r = 0; r < 4; r++) begin
      lng = 1'($urandom_range(0, 1));
      dv  = $urandom_range(1, 2);
      len = frame_len(lng);
      ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, len - 1)) : -1;
      dsv = (ab >= 0 && ab <= PRE) ? -1 : PRE;
      run_frame({$urandom, $urandom, $urandom, $urandom}, lng, dv, ab, 1'b0,
                (ab >= 0) ? ab + 1 + GUARD : len + GUARD, dsv);
    end

    // Reset in the middle of the data field (data sample 300).
    ena = 1'b1; start = 1'b1; long_frame = 1'b1; frame_data = GOLD_L;
    tick();
    start = 1'b0;
    repeat (PRE + 300) tick();
    check("pre_reset_busy", int'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_tx", int'(tx_pulse), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_strobes", int'(trigger) + int'(data_start) + int'(done), 0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tx_pulse || busy || done) bad++;
    end
    check("post_reset_quiet", bad, 0);
    run_frame(GOLD_L, 1'b1, 1, -1, 1'b0, 2400 + GUARD, PRE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
